demux1to4_stream: RTL and testbench
===================================

# demux1to4_stream

Stream demultiplexer: routes one N-bit input stream to one of four output channels selected per transfer by a 2-bit select, the inverse of the datapath 4-to-1 mux. Each output channel has a one-entry registered holding slot with its own valid/ready handshake, so a stalled consumer blocks only transfers addressed to it. It sits in the microarchitecture between a single pixel/word producer and up to four independent consumers (default N = 24).

## Interface
- N, 24, data width in bits
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk by the system
- D  input  N  input data word
- Sel  input  2  destination channel for the word on D (00→ch0 … 11→ch3); sampled only on an accepted transfer
- in_valid  input  1  D/Sel hold a word to transfer
- in_ready  output  1  block can accept the word this cycle
- Y0, Y1, Y2, Y3  output  N each  channel output data (registered)
- out_valid  output  4  bit i: channel i slot holds a word
- out_ready  input  4  bit i: consumer i takes the word this cycle

## Operation
- State per channel i: slot register Yi (N bits) and flag v[i]; out_valid = v.
- Reset (rst_n low): v = 4'b0000, Y0..Y3 = 0; in_ready therefore reads 1 while in_valid is ignored.
- in_ready = ~v[Sel] | out_ready[Sel] (combinational; depends only on the currently selected channel).
- Accept: in_valid & in_ready at a rising edge → Y[Sel] <= D, v[Sel] <= 1.
- Drain: v[i] & out_ready[i] at a rising edge → v[i] <= 0, unless the same edge accepts a word for channel i, in which case v[i] stays 1 and Yi takes the new word (back-to-back, no bubble).
- Non-selected channels are never written by an accept; they drain independently in the same cycle.
- Yi changes only on an accept into channel i; after a drain Yi keeps its last value (value is don't-care while v[i] = 0, but must not toggle).
- Stall: v[i] = 1 and out_ready[i] = 0 → Yi and v[i] held stable until taken.
- in_valid asserted with in_ready = 0: no state change; producer may hold or change D/Sel (no lock-in of Sel before acceptance).
- out_ready[i] while v[i] = 0: no effect.
- Ordering: words to the same channel leave in acceptance order; no ordering guarantee across channels.

## Timing
- Latency: word accepted at edge k appears on Yi with out_valid[i] = 1 immediately after edge k (one cycle).
- Throughput: one word per cycle sustained, on one channel or interleaved, while addressed consumers keep out_ready high.
- Combinational paths: Sel, out_ready, v → in_ready only; no path from D or in_valid to any output.
- Reset mid-operation: all slots invalidated asynchronously, held words discarded, Y0..Y3 forced to 0; first accept possible on the first edge after rst_n rises.

## Configuration
- DEMUX1TO4_RR_EN defined: destination comes from an internal 2-bit round-robin pointer instead of Sel; pointer resets to 0 and increments (mod 4, 3→0 wrap) on every accepted transfer; Sel is ignored; in_ready = ~v[ptr] | out_ready[ptr].
- Not defined: destination is Sel as described; no pointer register exists.

## Test plan
- Reset: rst_n low with in_valid = 1, D = 24'hABCDEF → out_valid = 0000, Y0..Y3 = 0, in_ready = 1; no slot loads.
- Single route: Sel = 2, D = 24'h123456, out_ready = 0000 → after one edge out_valid = 0100, Y2 = 24'h123456; then in_ready = 0 for Sel = 2 and 1 for Sel = 0.
- Stall/hold: ch1 full, out_ready[1] = 0 for 5 cycles while D changes → Y1 and out_valid[1] unchanged; out_ready[1] = 1 for one edge → out_valid[1] = 0, Y1 unchanged.
- Back-to-back same channel: out_ready = 1111, Sel = 3, D = 1,2,3,4 on consecutive edges → Y3 shows 1,2,3,4 with out_valid[3] continuously 1, in_ready never low.
- Simultaneous drain and accept on different channels: ch0 draining while word 24'h00FF00 goes to ch1 → out_valid 0001 → 0010 in one edge.
- DEMUX1TO4_RR_EN build: out_ready = 1111, Sel held at 0, five accepts → words land on ch0,1,2,3,0; reset mid-stream returns pointer to 0.

Source files
------------

// File: rtl/demux1to4_stream_if.sv
// demux1to4_stream_if: producer word/select handshake plus four independent consumer channels.
interface demux1to4_stream_if #(parameter int N = 24);
    logic [N-1:0] d;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y0, y1, y2, y3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    modport slave (
        input  d, sel, in_valid, out_ready,
        output in_ready, y0, y1, y2, y3, out_valid
    );
    modport master (
        output d, sel, in_valid, out_ready,
        input  in_ready, y0, y1, y2, y3, out_valid
    );
endinterface

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: routes one stream into four one-entry holding slots with per-channel handshake.
// DEMUX1TO4_RR_EN: destination from an internal round-robin pointer instead of sel.
module demux1to4_stream #(parameter int N = 24) (
    input logic               clk,
    input logic               rst_n,
    demux1to4_stream_if.slave bus
);
    logic [3:0]   v_q, v_d;
    logic [N-1:0] y_q [4];
    logic [1:0]   dst;
    logic         rdy, acc;
`ifdef DEMUX1TO4_RR_EN
    logic [1:0] ptr_q, ptr_d;
    assign dst   = ptr_q;
    assign ptr_d = ptr_q + {1'b0, acc};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end
`else
    assign dst = bus.sel;
`endif
    // A full slot can still accept when its consumer drains on the same edge.
    assign rdy = ~v_q[dst] | bus.out_ready[dst];
    assign acc = bus.in_valid & rdy;
    always_comb begin
        v_d = v_q & ~bus.out_ready;
        if (acc) v_d[dst] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 4'b0000;
            for (int i = 0; i < 4; i++) y_q[i] <= '0;
        end else begin
            v_q <= v_d;
            if (acc) y_q[dst] <= bus.d;
        end
    end
    assign bus.in_ready  = rdy;
    assign bus.out_valid = v_q;
    assign bus.y0        = y_q[0];
    assign bus.y1        = y_q[1];
    assign bus.y2        = y_q[2];
    assign bus.y3        = y_q[3];
endmodule

// File: tb/tb_demux1to4_stream.sv
// tb_demux1to4_stream: directed stimulus with per-channel expected-word queues checked by a monitor.
module tb_demux1to4_stream;
    logic clk = 1'b0;
    logic rst_n;
    int tests = 0;
    int fails = 0;
    logic [23:0] q [4][$];
    logic [23:0] yv [4];
    demux1to4_stream_if #(.N(24)) bus ();
    demux1to4_stream #(.N(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always_comb begin
        yv[0] = bus.y0;
        yv[1] = bus.y1;
        yv[2] = bus.y2;
        yv[3] = bus.y3;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic flush();
        for (int i = 0; i < 4; i++) q[i].delete();
    endtask
    // Issue one word expected to be accepted into channel ch on the next edge.
    task automatic send(input logic [1:0] s, input logic [23:0] w, input int ch);
        bus.sel = s;
        bus.d = w;
        bus.in_valid = 1'b1;
        #1;
        chk("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
        q[ch].push_back(w);
        step();
        bus.in_valid = 1'b0;
    endtask
    // Consumer side: a word leaving a slot must match the oldest word sent to that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL pop_ch%0d: got word %h expected no word", i, yv[i]);
                    end else begin
                        chk($sformatf("pop_ch%0d", i), {8'd0, yv[i]}, {8'd0, q[i].pop_front()});
                    end
                end
            end
        end
    end
    initial begin
        rst_n = 1'b0;
        bus.d = 24'hABCDEF;
        bus.sel = 2'd0;
        bus.in_valid = 1'b1;
        bus.out_ready = 4'b0000;
        repeat (3) step();
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_y0", {8'd0, bus.y0}, 32'd0);
        chk("rst_y1", {8'd0, bus.y1}, 32'd0);
        chk("rst_y2", {8'd0, bus.y2}, 32'd0);
        chk("rst_y3", {8'd0, bus.y3}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_out_valid", {28'd0, bus.out_valid}, 32'd0);
`ifndef DEMUX1TO4_RR_EN
        send(2'd2, 24'h123456, 2);
        chk("route_out_valid", {28'd0, bus.out_valid}, 32'b0100);
        chk("route_y2", {8'd0, bus.y2}, 32'h123456);
        bus.sel = 2'd2;
        #1;
        chk("route_rdy_sel2", {31'd0, bus.in_ready}, 32'd0);
        bus.sel = 2'd0;
        #1;
        chk("route_rdy_sel0", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        chk("route_drained", {28'd0, bus.out_valid}, 32'd0);
        send(2'd1, 24'hAAAAAA, 1);
        for (int k = 0; k < 5; k++) begin
            bus.sel = 2'd1;
            bus.d = 24'h000100 + 24'(k);
            bus.in_valid = 1'b1;
            #1;
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
            chk("stall_y1", {8'd0, bus.y1}, 32'hAAAAAA);
            chk("stall_out_valid", {28'd0, bus.out_valid}, 32'b0010);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b0010;
        step();
        bus.out_ready = 4'b0000;
        chk("stall_drained", {28'd0, bus.out_valid}, 32'd0);
        chk("stall_y1_kept", {8'd0, bus.y1}, 32'hAAAAAA);
        bus.out_ready = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            send(2'd3, 24'(k), 3);
            chk("b2b_valid3", {31'd0, bus.out_valid[3]}, 32'd1);
            chk("b2b_y3", {8'd0, bus.y3}, 32'(k));
        end
        step();
        chk("b2b_drained", {28'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 4'b0000;
        send(2'd0, 24'h111111, 0);
        chk("sim_pre", {28'd0, bus.out_valid}, 32'b0001);
        bus.out_ready = 4'b0001;
        send(2'd1, 24'h00FF00, 1);
        chk("sim_post", {28'd0, bus.out_valid}, 32'b0010);
        chk("sim_y1", {8'd0, bus.y1}, 32'h00FF00);
        chk("sim_y0_kept", {8'd0, bus.y0}, 32'h111111);
        bus.out_ready = 4'b0010;
        step();
        bus.out_ready = 4'b0000;
        chk("sim_drained", {28'd0, bus.out_valid}, 32'd0);
        send(2'd2, 24'h5A5A5A, 2);
        rst_n = 1'b0;
        flush();
        #1;
        chk("midrst_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("midrst_y2", {8'd0, bus.y2}, 32'd0);
        step();
        rst_n = 1'b1;
        send(2'd0, 24'h0BEEF0, 0);
        chk("midrst_first", {28'd0, bus.out_valid}, 32'b0001);
        bus.out_ready = 4'b0001;
        step();
        bus.out_ready = 4'b0000;
`else
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            send(2'd0, 24'h000010 + 24'(k), k % 4);
            chk("rr_out_valid", {28'd0, bus.out_valid}, 32'(1 << (k % 4)));
        end
        send(2'd0, 24'h000020, 1);
        send(2'd0, 24'h000021, 2);
        rst_n = 1'b0;
        flush();
        step();
        rst_n = 1'b1;
        send(2'd2, 24'h000030, 0);
        chk("rr_ptr_reset", {28'd0, bus.out_valid}, 32'b0001);
        chk("rr_y0", {8'd0, bus.y0}, 32'h000030);
        step();
        bus.out_ready = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("left_ch%0d", i), q[i].size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
